// File: rtl/johnson_pkg.sv
// Shared types and code constants for the Johnson counter phase monitor.
package johnson_pkg;

  typedef logic [2:0] phase_t;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    CHK    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_t;

  // Legal 4-bit Johnson codes, packed {q0,q1,q2,q3}, indexed by phase.
  localparam logic [3:0] CODE_P0 = 4'b0000;
  localparam logic [3:0] CODE_P1 = 4'b1000;
  localparam logic [3:0] CODE_P2 = 4'b1100;
  localparam logic [3:0] CODE_P3 = 4'b1110;
  localparam logic [3:0] CODE_P4 = 4'b1111;
  localparam logic [3:0] CODE_P5 = 4'b0111;
  localparam logic [3:0] CODE_P6 = 4'b0011;
  localparam logic [3:0] CODE_P7 = 4'b0001;

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson code to its phase index and a legality flag.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [3:0] jc,
  output phase_t     phase,
  output logic       legal
);

  always_comb begin
    phase = 3'd0;
    legal = 1'b1;
    case (jc)
      CODE_P0: phase = 3'd0;
      CODE_P1: phase = 3'd1;
      CODE_P2: phase = 3'd2;
      CODE_P3: phase = 3'd3;
      CODE_P4: phase = 3'd4;
      CODE_P5: phase = 3'd5;
      CODE_P6: phase = 3'd6;
      CODE_P7: phase = 3'd7;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a 4-bit Johnson counter, tracks sequence lock, and reports phase,
// revolutions and sequencing errors. All outputs are registered.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       jc,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             fault,
  output logic             wrap,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);

  phase_t           dec_phase;
  logic             dec_legal;
  mon_state_t       state;
  mon_state_t       state_next;
  phase_t           exp_ph;
  phase_t           exp_next;
  logic             hit;
  logic             lock_err;
  logic             lock_wrap;
  logic [CNT_W-1:0] err_base;

  johnson_decode u_decode (
    .jc    (jc),
    .phase (dec_phase),
    .legal (dec_legal)
  );

  assign hit       = dec_legal && (dec_phase == exp_ph);
  assign lock_err  = (state == LOCKED) && !hit;
  assign lock_wrap = (state == LOCKED) && hit && (dec_phase == 3'd0);
  // clr clears first so a coincident lock error still leaves a count of one.
  assign err_base  = clr ? '0 : err_cnt;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    exp_next   = exp_ph;
    case (state)
      ACQ: begin
        if (dec_legal) begin
          state_next = CHK;
          exp_next   = dec_phase + 3'd1;
        end
      end
      CHK: begin
        if (!dec_legal) begin
          state_next = ACQ;
        end else if (hit) begin
          state_next = LOCKED;
          exp_next   = exp_ph + 3'd1;
        end else begin
          exp_next   = dec_phase + 3'd1;
        end
      end
      LOCKED: begin
        if (hit) exp_next = exp_ph + 3'd1;
        else     state_next = FAULT;
      end
      FAULT:   state_next = ACQ;
      default: state_next = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACQ;
      exp_ph      <= 3'd0;
      phase       <= 3'd0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      fault       <= 1'b0;
      wrap        <= 1'b0;
      wrap_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_next;
      exp_ph      <= exp_next;
      phase       <= dec_phase;
      phase_valid <= dec_legal;
      locked      <= (state_next == LOCKED);
      seq_err     <= lock_err;
      wrap        <= lock_wrap;
      if (lock_wrap) wrap_cnt <= wrap_cnt + 1'b1;
      if (lock_err) begin
        fault   <= 1'b1;
        err_cnt <= (err_base == '1) ? err_base : err_base + 1'b1;
      end else if (clr) begin
        fault   <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomized scoreboard bench for johnson_phase_monitor against a behavioural model.
module tb_johnson_phase_monitor;

  localparam int CNT_W = 8;
  localparam int W     = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       jc;
  logic             clr;
  logic [2:0]       phase;
  logic             phase_valid;
  logic             locked;
  logic             seq_err;
  logic             fault;
  logic             wrap;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state_dbg;

  johnson_phase_monitor #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .jc          (jc),
    .clr         (clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .seq_err     (seq_err),
    .fault       (fault),
    .wrap        (wrap),
    .wrap_cnt    (wrap_cnt),
    .err_cnt     (err_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

  // Behavioural model: "run" counts consecutive in-order legal codes seen
  // while not locked; two in order means lock. A lost lock costs one dead cycle.
  bit m_locked = 0;
  bit m_hold   = 0;
  int m_run    = 0;
  int m_prev   = 0;
  int m_wrap   = 0;
  int m_err    = 0;
  bit m_fault  = 0;

  task automatic model_step();
    int ph;
    bit legal, sq, wr;
    logic [2:0] ph3;
    logic [7:0] wc8, ec8;
    ph = -1;
    for (int i = 0; i < 8; i++) if (codes[i] == jc) ph = i;
    legal = (ph >= 0);
    sq = 0;
    wr = 0;
    if (rst) begin
      m_locked = 0; m_hold = 0; m_run = 0; m_prev = 0;
      m_wrap = 0; m_err = 0; m_fault = 0;
      exp_q.push_back('0);
      return;
    end
    if (clr) begin
      m_err = 0;
      m_fault = 0;
    end
    if (m_locked) begin
      if (legal && ph == (m_prev + 1) % 8) begin
        m_prev = ph;
        if (ph == 0) begin
          wr = 1;
          m_wrap = (m_wrap + 1) % 256;
        end
      end else begin
        sq = 1;
        m_fault = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_locked = 0;
        m_hold = 1;
      end
    end else if (m_hold) begin
      m_hold = 0;
      m_run = 0;
    end else if (!legal) begin
      m_run = 0;
    end else if (m_run == 0) begin
      m_run = 1;
      m_prev = ph;
    end else begin
      if (ph == (m_prev + 1) % 8) m_locked = 1;
      m_prev = ph;
    end
    ph3 = legal ? ph[2:0] : 3'd0;
    wc8 = m_wrap[7:0];
    ec8 = m_err[7:0];
    exp_q.push_back({ph3, legal, m_locked, sq, m_fault, wr, wc8, ec8});
  endtask

  always @(posedge clk) model_step();

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {phase, phase_valid, locked, seq_err, fault, wrap, wrap_cnt, err_cnt};
      if (!e[20]) begin
        e[23:21] = 3'd0;
        g[23:21] = 3'd0;
      end
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got ph=%0d v=%0b lk=%0b se=%0b f=%0b w=%0b wc=%0d ec=%0d want ph=%0d v=%0b lk=%0b se=%0b f=%0b w=%0b wc=%0d ec=%0d",
                 $time, g[23:21], g[20], g[19], g[18], g[17], g[16], g[15:8], g[7:0],
                 e[23:21], e[20], e[19], e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  end

  // driver tasks
  int cnt = 0;

  task automatic drive(input logic [3:0] code, input logic c, input logic r);
    jc  = code;
    clr = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step_ok(input logic c);
    drive(codes[cnt], c, 1'b0);
    cnt = (cnt + 1) % 8;
  endtask

  task automatic step_force(input logic [3:0] code, input logic c);
    drive(code, c, 1'b0);
    cnt = (cnt + 1) % 8;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_ok(1'b0);
  endtask

  task automatic go_to(input int next_ph);
    while (cnt != next_ph) step_ok(1'b0);
  endtask

  initial begin
    jc = 4'b0000; clr = 1'b0; rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    cnt = 0;

    // start-up plus 256 full revolutions for wrap_cnt rollover
    run(256 * 8 + 3);

    // locked at phase 3: illegal code, then recovery
    go_to(4);
    step_force(4'b1010, 1'b0);
    run(10);

    // locked at phase 3: skip to phase 5
    go_to(4);
    step_force(4'b0111, 1'b0);
    run(10);

    // two more errors bring err_cnt to 4, then clr coincident with an error
    for (int k = 0; k < 2; k++) begin
      step_force(4'b0101, 1'b0);
      run(6);
    end
    step_force(4'b1001, 1'b1);
    run(6);
    step_ok(1'b1);
    run(4);

    // saturate err_cnt
    for (int k = 0; k < 260; k++) begin
      step_force(codes[(cnt + 2) % 8], 1'b0);
      run(4);
    end

    // randomized glitches and clears
    for (int i = 0; i < 1500; i++) begin
      logic c;
      c = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) step_force(4'($urandom_range(0, 15)), c);
      else step_ok(c);
    end

    // reset mid-LOCKED, with clr and an error code presented at the same edge
    run(8);
    drive(4'b1010, 1'b1, 1'b1);
    cnt = 0;
    run(12);

    // drain with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter. Registers the counter's four outputs and decodes them to a 3-bit phase index. Tracks the expected 8-step sequence with a lock FSM, flags illegal codes and out-of-sequence steps, and counts full revolutions and errors. Feeds phase enables and health status to downstream control logic.

## Interface
- `CNT_W`, default 8: width of `wrap_cnt` and `err_cnt`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset. Drive from the same reset as the counter.
- `jc` in 4: counter outputs packed as {q0,q1,q2,q3}; `jc[3]`=q0.
- `clr` in 1: single-cycle pulse; clears `fault` and `err_cnt`.
- `phase` out 3: decoded phase of the last sampled code.
- `phase_valid` out 1: last sampled code was legal.
- `locked` out 1: FSM is in LOCKED.
- `seq_err` out 1: one-cycle pulse on an error while LOCKED.
- `fault` out 1: sticky error flag.
- `wrap` out 1: one-cycle pulse on a 7→0 step while LOCKED.
- `wrap_cnt` out CNT_W: revolution count; wraps modulo 2^CNT_W.
- `err_cnt` out CNT_W: error count; saturates at all-ones.

## Operation
- Decode, applied to `jc`:
  - 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
  - The other 8 codes are illegal.
- `exp` is a 3-bit internal register holding the expected next phase. All increments are modulo 8.
- FSM states and transitions (evaluated each edge with `rst`=0):
  - ACQ: legal code → CHK, `exp`=phase+1. Illegal code → stay in ACQ.
  - CHK: code==`exp` → LOCKED, `exp`++. Legal mismatch → stay in CHK, reseed `exp`=phase+1. Illegal → ACQ.
  - LOCKED: code==`exp` → stay, `exp`++. Illegal code or mismatch → FAULT.
  - FAULT: unconditionally → ACQ on the next edge. The code sampled in FAULT is ignored.
- Entering FAULT from LOCKED, at that same edge:
  - `seq_err`=1 for one cycle.
  - `fault`=1.
  - `err_cnt`++, saturating.
- `wrap`: pulses when the FSM stays in LOCKED and the sampled phase is 0.
  - `wrap_cnt`++ on the same edge.
- Errors in ACQ and CHK are not counted and do not set `fault`.
- Simultaneous `clr` and an error entry to FAULT: the error wins. `fault` stays 1 and `err_cnt` becomes 1.
- `clr` does not affect FSM state, `wrap_cnt`, or `phase`.

## Timing
- Every output is a register, updated at the edge that samples `jc`. Latency is one cycle from code to output.
- Reset values:
  - `phase`=0, `phase_valid`=0, `locked`=0.
  - `seq_err`=0, `fault`=0, `wrap`=0.
  - `wrap_cnt`=0, `err_cnt`=0.
  - FSM state=ACQ, `exp`=0.
- `rst` asserted mid-operation returns all of the above to reset values at that edge. This overrides `clr` and any error.
- Normal start-up: the counter is reset to 0000 and `rst` falls before edge E1.
  - E1 samples 0000: `phase`=0, `phase_valid`=1, state CHK.
  - E2 samples 1000: `locked`=1, `phase`=1.
- Recovery after a fault: the fault edge, then one FAULT cycle, then ACQ, then CHK, then LOCKED. That is a minimum of 3 edges after the fault edge, given a clean sequence.
- The monitor expects one counter step per clock. There is no stall input.

## Structure
- Package `johnson_pkg`:
  - `typedef logic [2:0] phase_t`.
  - Enum `mon_state_t` {ACQ, CHK, LOCKED, FAULT}.
  - Localparams for the 8 legal codes.
- Sub-module `johnson_decode`: combinational, `jc`[3:0] → `phase_t` phase and `legal`.
- FSM, `exp`, flags and counters live in `johnson_phase_monitor`.

## Test plan
- Reset for 2 cycles, release, drive the counter sequence → E1: `phase`=0, `phase_valid`=1, `locked`=0. E2: `locked`=1, `phase`=1.
- Locked, run 8 steps → `wrap`=1 for one cycle at the sample of 0000. `wrap_cnt`=1. Repeat 256 revolutions → `wrap_cnt` rolls to 0.
- Locked at phase 3, force `jc`=1010 for one cycle → that edge: `seq_err`=1, `fault`=1, `err_cnt`=1, `phase_valid`=0, `locked`=0. Next edge: state ACQ. `locked` returns 2 edges later on a clean sequence.
- Locked at phase 3, force 0111 (skip to phase 5) → `seq_err`=1, `err_cnt`=1, `phase`=5, `phase_valid`=1, `locked`=0.
- Assert `clr` on the same edge as a new LOCKED error with `err_cnt`=4 → `err_cnt`=1, `fault`=1. `clr` alone later → `err_cnt`=0, `fault`=0, `locked` unaffected.
- Force 255+ errors with CNT_W=8 → `err_cnt` holds at 255. Then assert `rst` mid-LOCKED → all outputs return to reset values at that edge.
